// File: rtl/bus_arb_pkg.sv
// Shared definitions for the N-requestor bus arbiters: FSM encoding and
// arbitration-mode constants.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_GAP   = 2'd2
  } arb_state_e;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

endpackage

// File: rtl/arb_pick_n.sv
// Combinational winner select: lowest set request (fixed) or first set request
// scanning upward from ptr_i with wrap (round-robin). Shared by read/write arbiters.
module arb_pick_n #(
  parameter int N_REQ = 3,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDW-1:0]   ptr_i,
  input  logic             rr_mode_i,
  output logic [N_REQ-1:0] gnt_oh_o,
  output logic [IDW-1:0]   gnt_idx_o,
  output logic             valid_o
);

  localparam int SW = IDW + 1;

  logic          found;
  logic [SW-1:0] sum;
  logic [IDW-1:0] pos;

  // ptr_i and k are both below N_REQ, so one conditional subtract is a full modulo
  always_comb begin
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    sum       = '0;
    pos       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (rr_mode_i) begin
        sum = {1'b0, ptr_i} + SW'(k);
      end else begin
        sum = SW'(k);
      end
      if (sum >= SW'(N_REQ)) begin
        sum = sum - SW'(N_REQ);
      end
      pos = sum[IDW-1:0];
      if (!found && req_i[pos]) begin
        found          = 1'b1;
        gnt_oh_o[pos]  = 1'b1;
        gnt_idx_o      = pos;
      end
    end
  end

  assign valid_o = found;

endmodule

// File: rtl/bus_arbiter_n.sv
// N-requestor bus arbiter: grant held until finish or watchdog expiry, then one
// dead GAP cycle before the next IDLE decision. All outputs are registered.
module bus_arbiter_n
  import bus_arb_pkg::*;
#(
  parameter int N_REQ   = 3,
  parameter int RR_MODE = 1,
  parameter int TIMEOUT = 1024,
  parameter int IDW     = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             finish,
  output logic [N_REQ-1:0] gnt,
  output logic [N_REQ-1:0] sel,
  output logic [IDW-1:0]   gnt_id,
  output logic             busy,
  output logic             timeout_err
);

  localparam int             TW     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]  T_LAST = TW'(TIMEOUT - 1);
  localparam logic           RR_EN  = (RR_MODE == ARB_RR);

  arb_state_e       state_q;
  logic [N_REQ-1:0] gnt_q;
  logic [IDW-1:0]   gnt_id_q;
  logic             busy_q;
  logic             terr_q;
  logic [IDW-1:0]   ptr_q;
  logic [IDW-1:0]   ptr_d;
  logic [TW-1:0]    timer_q;

  logic [N_REQ-1:0] pick_oh;
  logic [IDW-1:0]   pick_idx;
  logic             pick_valid;
  logic             wd_hit;

  arb_pick_n #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_pick (
    .req_i     (req),
    .ptr_i     (ptr_q),
    .rr_mode_i (RR_EN),
    .gnt_oh_o  (pick_oh),
    .gnt_idx_o (pick_idx),
    .valid_o   (pick_valid)
  );

  assign ptr_d  = (pick_idx == IDW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
  assign wd_hit = (TIMEOUT != 0) && (timer_q == T_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ARB_IDLE;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      busy_q   <= 1'b0;
      terr_q   <= 1'b0;
      ptr_q    <= '0;
      timer_q  <= '0;
    end else begin
      terr_q <= 1'b0;
      case (state_q)
        ARB_IDLE: begin
          if (pick_valid) begin
            gnt_q    <= pick_oh;
            gnt_id_q <= pick_idx;
            busy_q   <= 1'b1;
            timer_q  <= '0;
            state_q  <= ARB_GRANT;
            if (RR_EN) begin
              ptr_q <= ptr_d;
            end
          end
        end
        ARB_GRANT: begin
          if (timer_q != '1) begin
            timer_q <= timer_q + 1'b1;
          end
          // finish takes precedence over a coincident watchdog expiry
          if (finish) begin
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= ARB_GAP;
          end else if (wd_hit) begin
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            terr_q  <= 1'b1;
            state_q <= ARB_GAP;
          end
        end
        ARB_GAP: begin
          state_q <= ARB_IDLE;
        end
        default: begin
          state_q <= ARB_IDLE;
        end
      endcase
    end
  end

  assign gnt         = gnt_q;
  assign sel         = gnt_q;
  assign gnt_id      = gnt_id_q;
  assign busy        = busy_q;
  assign timeout_err = terr_q;

endmodule
